// File: rtl/multi_cycle_control_pkg.sv
// multi_cycle_control_pkg
// Shared constants for the multi-cycle MIPS control path: opcode values,
// aluOp encodings consumed by the ALU control stage, and the main-FSM state
// encoding.
// Optional feature macro: MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN adds the HALT state.
package multi_cycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_OPC   = 2'b11
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADR   = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_I_EXEC    = 4'd10,
        S_I_WB      = 4'd11
`ifdef MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN
        ,
        S_HALT      = 4'd12
`endif
    } state_t;

endpackage

// File: rtl/multi_cycle_control.sv
// multi_cycle_control
// Main control FSM of the multi-cycle MIPS datapath. Sequences each
// instruction through fetch/decode/execute/memory/writeback and drives all
// datapath enables and mux selects.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   opcode[5:0]           instr[31:26] from the instruction register
//   memReady              memory access completes in a cycle where this is 1
//   pcWrite, pcWriteCond  PC load (unconditional / on ALU zero)
//   iorD, memRead, memWrite, irWrite   memory interface controls
//   memToReg, regDst, regWrite         register file controls
//   aluSrcA, aluSrcB[1:0], aluOp[1:0]  ALU operand / operation selects
//   pcSource[1:0]         PC source select
//   state[STATE_W-1:0]    current state, for debug
//   illegalOp             sticky illegal-opcode flag
// Optional feature macro: MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN traps unknown
// opcodes into HALT (left only by reset); otherwise they act as NOPs.
module multi_cycle_control
    import multi_cycle_control_pkg::*;
#(
    parameter int unsigned STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               memReady,
    output logic               pcWrite,
    output logic               pcWriteCond,
    output logic               iorD,
    output logic               memRead,
    output logic               memWrite,
    output logic               irWrite,
    output logic               memToReg,
    output logic               regDst,
    output logic               regWrite,
    output logic               aluSrcA,
    output logic [1:0]         aluSrcB,
    output logic [1:0]         aluOp,
    output logic [1:0]         pcSource,
    output logic [STATE_W-1:0] state,
    output logic               illegalOp
);

    state_t cur_state;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cur_state <= S_FETCH;
        end else begin
            case (cur_state)
                S_FETCH:     if (memReady) cur_state <= S_DECODE;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:     cur_state <= S_MEM_ADR;
                        OP_RTYPE:         cur_state <= S_R_EXEC;
                        OP_BEQ:           cur_state <= S_BRANCH;
                        OP_J:             cur_state <= S_JUMP;
                        OP_ADDI, OP_ANDI: cur_state <= S_I_EXEC;
`ifdef MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN
                        default:          cur_state <= S_HALT;
`else
                        default:          cur_state <= S_FETCH;
`endif
                    endcase
                end
                S_MEM_ADR:   cur_state <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
                S_MEM_READ:  if (memReady) cur_state <= S_MEM_WB;
                S_MEM_WB:    cur_state <= S_FETCH;
                S_MEM_WRITE: if (memReady) cur_state <= S_FETCH;
                S_R_EXEC:    cur_state <= S_R_WB;
                S_R_WB:      cur_state <= S_FETCH;
                S_BRANCH:    cur_state <= S_FETCH;
                S_JUMP:      cur_state <= S_FETCH;
                S_I_EXEC:    cur_state <= S_I_WB;
                S_I_WB:      cur_state <= S_FETCH;
`ifdef MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN
                S_HALT:      cur_state <= S_HALT;
`endif
                default:     cur_state <= S_FETCH;
            endcase
        end
    end

    // Moore decode; only the FETCH-cycle PC/IR loads look at memReady so
    // they fire exactly once, in the cycle the instruction word arrives.
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = ALU_ADD;
        pcSource    = 2'b00;
        illegalOp   = 1'b0;
        case (cur_state)
            S_FETCH: begin
                memRead = 1'b1;
                aluSrcB = 2'b01;
                irWrite = memReady;
                pcWrite = memReady;
            end
            S_DECODE:    aluSrcB = 2'b11;
            S_MEM_ADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEM_READ: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MEM_WRITE: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            S_R_EXEC: begin
                aluSrcA = 1'b1;
                aluOp   = ALU_FUNCT;
            end
            S_R_WB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = ALU_SUB;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
            end
            S_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = 2'b10;
            end
            S_I_EXEC: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                aluOp   = (opcode == OP_ANDI) ? ALU_OPC : ALU_ADD;
            end
            S_I_WB:      regWrite = 1'b1;
`ifdef MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN
            // Sticky by construction: HALT is left only through reset.
            S_HALT:      illegalOp = 1'b1;
`endif
            default: ;
        endcase
    end

    assign state = STATE_W'(cur_state);

endmodule

// File: tb/tb_multi_cycle_control.sv
// tb_multi_cycle_control
// Self-checking bench for multi_cycle_control: an instruction-level model
// (per-opcode step lists and per-step output rules) is compared against the
// DUT on every negative clock edge, plus directed latency/boundary checks.
module tb_multi_cycle_control;
    import multi_cycle_control_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = OP_RTYPE;
    logic       memReady = 1'b1;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA, illegalOp;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    multi_cycle_control #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSource(pcSource), .state(state), .illegalOp(illegalOp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- instruction-level model ----------------
    function automatic int len_of(input logic [5:0] op);
        case (op)
            OP_LW:                               return 5;
            OP_SW, OP_RTYPE, OP_ADDI, OP_ANDI:   return 4;
            OP_BEQ, OP_J:                        return 3;
`ifdef MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN
            default:                             return 3;
`else
            default:                             return 2;
`endif
        endcase
    endfunction

    function automatic state_t step_of(input logic [5:0] op, input int idx);
        if (idx == 0) return S_FETCH;
        if (idx == 1) return S_DECODE;
        case (op)
            OP_LW:   return (idx == 2) ? S_MEM_ADR : (idx == 3) ? S_MEM_READ : S_MEM_WB;
            OP_SW:   return (idx == 2) ? S_MEM_ADR : S_MEM_WRITE;
            OP_RTYPE: return (idx == 2) ? S_R_EXEC : S_R_WB;
            OP_BEQ:  return S_BRANCH;
            OP_J:    return S_JUMP;
            OP_ADDI, OP_ANDI: return (idx == 2) ? S_I_EXEC : S_I_WB;
`ifdef MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN
            default: return S_HALT;
`else
            default: return S_FETCH;
`endif
        endcase
    endfunction

    function automatic bit is_halt(input state_t s);
`ifdef MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN
        return s == S_HALT;
`else
        return (s != s);
`endif
    endfunction

    // {pcWrite,pcWriteCond,iorD,memRead,memWrite,irWrite,memToReg,regDst,
    //  regWrite,aluSrcA,aluSrcB,aluOp,pcSource,illegalOp}
    function automatic logic [16:0] exp_vec(input state_t s, input logic rdy, input logic [5:0] op);
        logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, ill;
        logic [1:0] sb, ao, ps;
        {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
        sb = 2'b00; ao = 2'b00; ps = 2'b00;
        if (s == S_FETCH)     begin mr = 1; sb = 2'b01; irw = rdy; pw = rdy; end
        if (s == S_DECODE)    sb = 2'b11;
        if (s == S_MEM_ADR)   begin sa = 1; sb = 2'b10; end
        if (s == S_MEM_READ)  begin mr = 1; iod = 1; end
        if (s == S_MEM_WB)    begin rw = 1; m2r = 1; end
        if (s == S_MEM_WRITE) begin mw = 1; iod = 1; end
        if (s == S_R_EXEC)    begin sa = 1; ao = 2'b10; end
        if (s == S_R_WB)      begin rw = 1; rd = 1; end
        if (s == S_BRANCH)    begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
        if (s == S_JUMP)      begin pw = 1; ps = 2'b10; end
        if (s == S_I_EXEC)    begin sa = 1; sb = 2'b10; ao = (op == OP_ANDI) ? 2'b11 : 2'b00; end
        if (s == S_I_WB)      rw = 1;
        if (is_halt(s))       ill = 1;
        return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, ill};
    endfunction

    int         m_idx = 0;
    logic [5:0] m_op = '0;
    logic [5:0] eff_op;
    state_t     exp_state;

    always_comb begin
        eff_op    = (m_idx < 2) ? opcode : m_op;
        exp_state = step_of(eff_op, m_idx);
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            m_idx <= 0;
        end else if ((exp_state == S_FETCH || exp_state == S_MEM_READ ||
                      exp_state == S_MEM_WRITE) && !memReady) begin
            m_idx <= m_idx;
        end else if (is_halt(exp_state)) begin
            m_idx <= m_idx;
        end else if (m_idx + 1 >= len_of(eff_op)) begin
            m_idx <= 0;
        end else begin
            m_idx <= m_idx + 1;
        end
        if (rst_n && m_idx == 1) m_op <= opcode;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", 32'(state), 32'(exp_state));
            chk("outputs",
                32'({pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                     regDst, regWrite, aluSrcA, aluSrcB, aluOp, pcSource, illegalOp}),
                32'(exp_vec(exp_state, memReady, opcode)));
        end
    end

    // ---------------- directed + random stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Runs one instruction from FETCH, stalling MEM_READ/MEM_WRITE 'stalls' cycles.
    task automatic measure(input logic [5:0] op, input int stalls,
                           output int cyc, output int mem_cyc, output int wr_cyc);
        int left;
        left = stalls;
        cyc = 0; mem_cyc = 0; wr_cyc = 0;
        opcode = op;
        for (int k = 0; k < 40; k++) begin
            memReady = ((state == 4'(S_MEM_READ) || state == 4'(S_MEM_WRITE)) && left > 0) ? 1'b0 : 1'b1;
            if (!memReady) left--;
            #1;
            if (memRead && iorD) mem_cyc++;
            if (regWrite) wr_cyc++;
            @(posedge clk);
            #2;
            cyc++;
            if (state == 4'(S_FETCH)) break;
        end
    endtask

    logic [5:0] op_tab [7] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI};

    initial begin
        int c, mc, wc;
        rst_n = 1'b0; memReady = 1'b1; opcode = OP_RTYPE;
        tick();
        chk_en = 1'b1;
        tick();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_memRead", 32'(memRead), 32'd1);
        chk("rst_irWrite", 32'(irWrite), 32'd1);
        chk("rst_pcWrite", 32'(pcWrite), 32'd1);
        chk("rst_aluOp", 32'(aluOp), 32'd0);
        chk("rst_regWrite", 32'(regWrite), 32'd0);
        chk("rst_illegalOp", 32'(illegalOp), 32'd0);
        rst_n = 1'b1;

        measure(OP_RTYPE, 0, c, mc, wc);
        chk("rtype_cycles", 32'(c), 32'd4);
        chk("rtype_writes", 32'(wc), 32'd1);
        measure(OP_LW, 3, c, mc, wc);
        chk("lw_stall_cycles", 32'(c), 32'd8);
        chk("lw_stall_memread_iord", 32'(mc), 32'd4);
        chk("lw_writes", 32'(wc), 32'd1);
        measure(OP_SW, 0, c, mc, wc);
        chk("sw_cycles", 32'(c), 32'd4);
        measure(OP_BEQ, 0, c, mc, wc);
        chk("beq_cycles", 32'(c), 32'd3);
        chk("beq_writes", 32'(wc), 32'd0);
        measure(OP_ANDI, 0, c, mc, wc);
        chk("andi_cycles", 32'(c), 32'd4);
        measure(OP_J, 0, c, mc, wc);
        chk("j_cycles", 32'(c), 32'd3);

        // Reset in the middle of a stalled store.
        opcode = OP_SW; memReady = 1'b1;
        for (int k = 0; k < 10 && state != 4'(S_MEM_WRITE); k++) tick();
        memReady = 1'b0;
        tick();
        chk("sw_stall_memWrite", 32'(memWrite), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("rst_in_stall_state", 32'(state), 32'd0);
        chk("rst_in_stall_memWrite", 32'(memWrite), 32'd0);
        rst_n = 1'b1; memReady = 1'b1;
        tick();

`ifdef MULTI_CYCLE_CONTROL_ILLEGAL_TRAP_EN
        for (int k = 0; k < 10 && state != 4'(S_FETCH); k++) tick();
        opcode = 6'b111111;
        tick(); tick();
        for (int k = 0; k < 10; k++) begin
            memReady = 1'($urandom_range(0, 1));
            #1;
            chk("halt_illegalOp", 32'(illegalOp), 32'd1);
            chk("halt_state", 32'(state), 32'(S_HALT));
            tick();
        end
        rst_n = 1'b0; memReady = 1'b1;
        tick();
        chk("halt_reset_state", 32'(state), 32'd0);
        chk("halt_reset_illegalOp", 32'(illegalOp), 32'd0);
        rst_n = 1'b1;
`else
        for (int k = 0; k < 10 && state != 4'(S_FETCH); k++) tick();
        measure(6'b111111, 0, c, mc, wc);
        chk("unknown_cycles", 32'(c), 32'd2);
        chk("unknown_writes", 32'(wc), 32'd0);
`endif

        for (int n = 0; n < 3000; n++) begin
            if (exp_state == S_FETCH) begin
                if ($urandom_range(0, 19) == 0) opcode = 6'($urandom);
                else opcode = op_tab[$urandom_range(0, 6)];
            end
            memReady = ($urandom_range(0, 3) != 0);
            rst_n = ($urandom_range(0, 99) != 0);
            tick();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
